// File: rtl/stopwatch_ctrl.sv
// Run/pause/stop sequencer and 4-digit packed-BCD count for the stopwatch datapath.
// Lap capture is built only when STOPWATCH_LAP_EN is defined; otherwise lap_q is tied to zero.
module stopwatch_ctrl #(
  parameter int PRESCALE = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  input  logic [15:0] limit,
  output logic [15:0] count,
  output logic [15:0] lap_q,
  output logic        running,
  output logic        done,
  output logic        wrap,
  output logic        tick,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  state_t      state, state_next;
  logic [15:0] presc;
  logic [15:0] count_inc;
  logic        inc_hit;
  logic        limit_hit;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic        carry;
    logic [15:0] r;
    carry = 1'b1;
    r     = v;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A limit with a non-BCD digit can never equal a valid BCD count, so it free-runs.
  assign count_inc = bcd_inc(count);
  assign inc_hit   = (state == RUN) && (presc == PRESC_LAST);
  assign limit_hit = inc_hit && (limit != 16'h0000) && (count_inc == limit);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if (start && !stop) state_next = RUN;
        RUN: begin
          if (limit_hit) state_next = DONE;
          else if (stop) state_next = PAUSE;
        end
        PAUSE: if (start && !stop) state_next = RUN;
        DONE:  state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Counting follows the current state, so a stop on an increment edge still increments.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      presc <= 16'h0000;
      count <= 16'h0000;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (state == RUN) begin
        if (inc_hit) begin
          presc <= 16'h0000;
          count <= count_inc;
          tick  <= 1'b1;
          wrap  <= (count == 16'h9999);
        end else begin
          presc <= presc + 16'h0001;
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk) begin
    if (reset || clear)                                lap_q <= 16'h0000;
    else if (lap && (state == RUN || state == PAUSE))  lap_q <= count;
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_q      = 16'h0000;
`endif

  assign running   = (state == RUN);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: one PRESCALE=4 and one PRESCALE=2 instance on shared inputs.
// Lap expectations follow STOPWATCH_LAP_EN the same way the design build does.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] limit = 16'h0000;

  logic [15:0] count4, lap_q4, count2, lap_q2;
  logic        running4, done4, wrap4, tick4;
  logic        running2, done2, wrap2, tick2;
  logic [1:0]  state4, state2;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_q[$];
  logic [15:0] lap_exp;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .limit(limit), .count(count4), .lap_q(lap_q4), .running(running4), .done(done4),
    .wrap(wrap4), .tick(tick4), .fsm_state(state4)
  );

  stopwatch_ctrl #(.PRESCALE(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .limit(limit), .count(count2), .lap_q(lap_q2), .running(running2), .done(done2),
    .wrap(wrap2), .tick(tick2), .fsm_state(state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the edge's result visible.
  task automatic strobe(input logic s, input logic st, input logic cl, input logic lp);
    start = s; stop = st; clear = cl; lap = lp;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_count",   count4,   16'h0000);
    check("rst_lap_q",   lap_q4,   16'h0000);
    check("rst_running", running4, 1'b0);
    check("rst_done",    done4,    1'b0);
    check("rst_tick",    tick4,    1'b0);
    check("rst_wrap",    wrap4,    1'b0);
    check("rst_state",   state4,   2'b00);

    // Count 0001..0010 at PRESCALE=4, including the 0009->0010 digit carry.
    for (int i = 1; i <= 9; i++) exp_q.push_back(16'(i));
    exp_q.push_back(16'h0010);
    strobe(1, 0, 0, 0);
    check("start_running", running4, 1'b1);
    check("start_count",   count4,   16'h0000);
    for (int k = 0; k < 10; k++) begin
      wait_cycles(3);
      check("pre_tick_low", tick4, 1'b0);
      wait_cycles(1);
      check("tick_high", tick4, 1'b1);
      check("count_seq", count4, exp_q.pop_front());
    end

    // start+stop+clear together in RUN: clear wins.
    strobe(1, 1, 1, 0);
    check("all_cmd_state", state4, 2'b00);
    check("all_cmd_count", count4, 16'h0000);

    // Pause at 0005 with two prescaler steps consumed, then resume with the remainder.
    do_reset();
    strobe(1, 0, 0, 0);
    wait_cycles(20);
    check("at_five", count4, 16'h0005);
    wait_cycles(1);
    strobe(0, 1, 0, 0);
    check("pause_state",   state4,   2'b10);
    check("pause_running", running4, 1'b0);
    wait_cycles(20);
    check("pause_hold", count4, 16'h0005);
    strobe(1, 0, 0, 0);
    check("resume_running", running4, 1'b1);
    wait_cycles(1);
    check("resume_no_tick", count4, 16'h0005);
    wait_cycles(1);
    check("resume_tick",  tick4,  1'b1);
    check("resume_count", count4, 16'h0006);
    strobe(0, 1, 0, 0);
    strobe(1, 1, 0, 0);
    check("pause_startstop", state4, 2'b10);

    // Limit 0012 at PRESCALE=2.
    limit = 16'h0012;
    do_reset();
    strobe(1, 0, 0, 0);
    wait_cycles(22);
    check("lim_11_count",   count2,   16'h0011);
    check("lim_11_running", running2, 1'b1);
    wait_cycles(2);
    check("lim_count",   count2,   16'h0012);
    check("lim_done",    done2,    1'b1);
    check("lim_running", running2, 1'b0);
    check("lim_state",   state2,   2'b11);
    wait_cycles(5);
    strobe(1, 0, 0, 0);
    strobe(0, 1, 0, 0);
    strobe(0, 0, 0, 1);
    wait_cycles(3);
    check("done_hold_count", count2, 16'h0012);
    check("done_hold_state", state2, 2'b11);
    check("done_lap_ignored", lap_q2, 16'h0000);
    strobe(0, 0, 1, 0);
    check("clr_state", state2, 2'b00);
    check("clr_count", count2, 16'h0000);
    check("clr_done",  done2,  1'b0);
    limit = 16'h0000;

    // Lap on the edge that takes 0007 to 0008.
    do_reset();
    strobe(1, 0, 0, 0);
    wait_cycles(28);
    check("lap_pre_count", count4, 16'h0007);
    wait_cycles(3);
    strobe(0, 0, 0, 1);
`ifdef STOPWATCH_LAP_EN
    lap_exp = 16'h0007;
`else
    lap_exp = 16'h0000;
`endif
    check("lap_q",      lap_q4, lap_exp);
    check("lap_count",  count4, 16'h0008);
    check("lap_tick",   tick4,  1'b1);

    // Rollover at PRESCALE=2: 9999 increments end two negedges apart.
    do_reset();
    strobe(1, 0, 0, 0);
    wait_cycles(19998);
    check("wrap_9999",      count2, 16'h9999);
    check("wrap_9999_wrap", wrap2,  1'b0);
    wait_cycles(1);
    check("wrap_mid_tick", tick2, 1'b0);
    wait_cycles(1);
    check("wrap_count",   count2,   16'h0000);
    check("wrap_pulse",   wrap2,    1'b1);
    check("wrap_tick",    tick2,    1'b1);
    check("wrap_running", running2, 1'b1);
    wait_cycles(1);
    check("wrap_one_cycle", wrap2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
